// File: rtl/agc_gain_ctrl.sv
// agc_gain_ctrl: windowed |din| average addresses a gain table; returned gain drives a saturating multiply
module agc_gain_ctrl #(
  parameter int DIN_WIDTH = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int N_ADDR = 256,
  parameter int WIN_LOG2 = 6,
  localparam int AW = $clog2(N_ADDR)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_valid,
  output logic                         ren,
  output logic [AW-1:0]                radd,
  input  logic [GAIN_WIDTH-1:0]        gain_in,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic [GAIN_WIDTH-1:0]        cur_gain,
  output logic                         gain_upd
);
  localparam int MW = DIN_WIDTH - 1;
  localparam int ACW = MW + WIN_LOG2;
  localparam int PW = DIN_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [PW-1:0] DMAX = PW'((2 ** (DOUT_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] DMIN = ~DMAX;
  typedef enum logic [1:0] {ACCUM, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic [MW-1:0] mag;
  logic [ACW-1:0] acc, sum;
  logic [WIN_LOG2-1:0] cnt;
  logic close, v1;
  logic signed [PW-1:0] prod, prod_c, shr;
  // the most-negative sample folds onto the largest positive magnitude
  assign mag = din[DIN_WIDTH-1] ? ((din == {1'b1, {MW{1'b0}}}) ? '1 : MW'(-din)) : din[MW-1:0];
  assign sum = acc + ACW'(mag);
  assign close = din_valid && (&cnt);
  assign prod_c = PW'(din) * PW'($signed({1'b0, cur_gain}));
  assign shr = prod >>> (GAIN_WIDTH - 1);
  always_comb begin
    ren = state == REQ;
    state_nx = state == REQ ? WAIT : state == WAIT ? ACCUM : close ? REQ : ACCUM;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      radd <= '0;
      cur_gain <= {1'b1, {(GAIN_WIDTH-1){1'b0}}};
      gain_upd <= 1'b0;
    end else begin
      state <= state_nx;
      if (din_valid) begin
        acc <= close ? '0 : sum;
        cnt <= cnt + 1'b1;
      end
      if (close) radd <= sum[ACW-1 -: AW];
      gain_upd <= state == WAIT;
      if (state == WAIT) cur_gain <= gain_in;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      prod <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      v1 <= din_valid;
      if (din_valid) prod <= prod_c;
      dout_valid <= v1;
      if (v1) dout <= shr > DMAX ? DOUT_WIDTH'(DMAX) : shr < DMIN ? DOUT_WIDTH'(DMIN) : DOUT_WIDTH'(shr);
    end
endmodule

// File: tb/tb_agc_gain_ctrl.sv
// tb_agc_gain_ctrl: directed scenarios plus randomized traffic against a cycle-timed behavioural model
module tb_agc_gain_ctrl;
  logic clk = 0, rst_n = 0;
  logic signed [15:0] din = 0;
  logic din_valid = 0;
  logic ren;
  logic [7:0] radd;
  logic [15:0] gain_in = 0;
  logic signed [15:0] dout;
  logic dout_valid;
  logic [15:0] cur_gain;
  logic gain_upd;
  int n_tests = 0, n_fail = 0;
  logic [15:0] tbl [256];

  always #5 clk = ~clk;

  agc_gain_ctrl dut (.clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .ren(ren), .radd(radd),
                     .gain_in(gain_in), .dout(dout), .dout_valid(dout_valid), .cur_gain(cur_gain), .gain_upd(gain_upd));

  always @(posedge clk) if (ren) gain_in <= tbl[radd];

  // reference model: window sums in plain integers, lookup as scheduled cycle events
  int cyc = 0, m_gain = 32768, m_sum = 0, m_cnt = 0, m_radd = 0, m_ren_at = -1, m_upd_at = -1, e1 = 0, e2 = 0;
  bit e1v = 0, e2v = 0, m_upd = 0;

  function automatic int mag_of(int d);
    return d == -32768 ? 32767 : (d < 0 ? -d : d);
  endfunction

  function automatic int gained(int d, int g);
    longint p;
    p = (longint'(d) * longint'(g)) >>> 15;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gain = 32768; m_sum = 0; m_cnt = 0; m_radd = 0; m_ren_at = -1; m_upd_at = -1;
      e1 = 0; e2 = 0; e1v = 0; e2v = 0; m_upd = 0;
    end else begin
      cyc++;
      m_upd = 0;
      if (e1v) e2 = e1;
      e2v = e1v;
      e1v = din_valid;
      if (din_valid) e1 = gained(int'(din), m_gain);
      if (m_upd_at == cyc) begin m_gain = int'(tbl[m_radd]); m_upd = 1; end
      if (din_valid) begin
        m_sum += mag_of(int'(din));
        m_cnt++;
        if (m_cnt == 64) begin
          m_radd = (m_sum / 64) / 128;
          m_sum = 0; m_cnt = 0; m_ren_at = cyc; m_upd_at = cyc + 2;
        end
      end
    end
  end

  task automatic tick(input int d, input bit v);
    din = 16'(d);
    din_valid = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    din_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_tests++; if (dout !== 16'sd0) begin n_fail++; $display("FAIL reset_dout: got %0d want 0", dout); end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    n_tests++; if (ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b want 0", ren); end
    n_tests++; if (cur_gain !== 16'h8000) begin n_fail++; $display("FAIL reset_cur_gain: got %h want 8000", cur_gain); end
    n_tests++; if (gain_upd !== 1'b0) begin n_fail++; $display("FAIL reset_gain_upd: got %b want 0", gain_upd); end
  endtask

  task automatic test_unity();
    tick(1000, 1);
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL unity_early_valid: got %b want 0", dout_valid); end
    tick(0, 0);
    n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL unity_valid: got %b want 1", dout_valid); end
    n_tests++; if (dout !== 16'sd1000) begin n_fail++; $display("FAIL unity_dout: got %0d want 1000", dout); end
    tick(0, 0);
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL unity_valid_drop: got %b want 0", dout_valid); end
  endtask

  task automatic test_window();
    int rc = 0;
    do_reset();
    foreach (tbl[i]) tbl[i] = 16'h4000;
    for (int i = 0; i < 63; i++) begin tick((i % 2) ? -8192 : 8192, 1); rc += ren; end
    n_tests++; if (rc != 0) begin n_fail++; $display("FAIL window_early_ren: got %0d pulses want 0", rc); end
    tick(-8192, 1);
    n_tests++; if (ren !== 1'b1) begin n_fail++; $display("FAIL window_ren: got %b want 1", ren); end
    n_tests++; if (radd !== 8'd64) begin n_fail++; $display("FAIL window_radd: got %0d want 64", radd); end
    tick(0, 0);
    n_tests++; if (ren !== 1'b0) begin n_fail++; $display("FAIL window_ren_width: got %b want 0", ren); end
    n_tests++; if (gain_upd !== 1'b0) begin n_fail++; $display("FAIL window_upd_early: got %b want 0", gain_upd); end
    tick(0, 0);
    n_tests++; if (gain_upd !== 1'b1) begin n_fail++; $display("FAIL window_upd: got %b want 1", gain_upd); end
    n_tests++; if (cur_gain !== 16'h4000) begin n_fail++; $display("FAIL window_gain: got %h want 4000", cur_gain); end
    tick(1000, 1);
    n_tests++; if (gain_upd !== 1'b0) begin n_fail++; $display("FAIL window_upd_width: got %b want 0", gain_upd); end
    tick(-3, 1);
    n_tests++; if (dout !== 16'sd500) begin n_fail++; $display("FAIL half_gain_dout: got %0d want 500", dout); end
    tick(0, 0);
    n_tests++; if (dout !== -16'sd2) begin n_fail++; $display("FAIL floor_dout: got %0d want -2", dout); end
    tick(0, 0);
    n_tests++; if (dout_valid !== 1'b0 || dout !== -16'sd2) begin n_fail++; $display("FAIL hold_dout: got %0d/%b want -2/0", dout, dout_valid); end
  endtask

  task automatic test_saturate();
    do_reset();
    foreach (tbl[i]) tbl[i] = 16'hFFFF;
    repeat (64) tick(-32768, 1);
    n_tests++; if (ren !== 1'b1 || radd !== 8'd255) begin n_fail++; $display("FAIL sat_radd: got ren=%b radd=%0d want 1/255", ren, radd); end
    tick(0, 0);
    tick(0, 0);
    n_tests++; if (cur_gain !== 16'hFFFF) begin n_fail++; $display("FAIL sat_gain: got %h want ffff", cur_gain); end
    tick(32767, 1);
    tick(-32768, 1);
    n_tests++; if (dout !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos: got %0d want 32767", dout); end
    tick(0, 0);
    n_tests++; if (dout !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg: got %0d want -32768", dout); end
  endtask

  task automatic test_gaps();
    int rc = 0;
    do_reset();
    foreach (tbl[i]) tbl[i] = 16'h4000;
    for (int i = 0; i < 64; i++) begin
      tick(4096, 1);
      rc += ren;
      if (i < 63) repeat (2) begin tick(int'($urandom), 0); rc += ren; end
    end
    n_tests++; if (ren !== 1'b1 || radd !== 8'd32) begin n_fail++; $display("FAIL gaps_radd: got ren=%b radd=%0d want 1/32", ren, radd); end
    repeat (6) begin tick(0, 0); rc += ren; end
    n_tests++; if (rc != 1) begin n_fail++; $display("FAIL gaps_ren_count: got %0d want 1", rc); end
  endtask

  task automatic test_reset_abort();
    int rc = 0, uc = 0;
    do_reset();
    foreach (tbl[i]) tbl[i] = 16'(1 + $urandom_range(0, 16'h7FFE));
    repeat (64) tick(int'($urandom_range(0, 20000)), 1);
    tick(5, 1);
    #1 rst_n = 0;
    #1;
    n_tests++; if (gain_upd !== 1'b0) begin n_fail++; $display("FAIL abort_upd: got %b want 0", gain_upd); end
    n_tests++; if (cur_gain !== 16'h8000) begin n_fail++; $display("FAIL abort_gain: got %h want 8000", cur_gain); end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", dout_valid); end
    @(negedge clk);
    din_valid = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (4) begin tick(0, 0); uc += gain_upd; end
    n_tests++; if (uc != 0 || cur_gain !== 16'h8000) begin n_fail++; $display("FAIL abort_late_upd: got %0d pulses gain %h want 0/8000", uc, cur_gain); end
    repeat (63) begin tick(3000, 1); rc += ren; end
    n_tests++; if (rc != 0) begin n_fail++; $display("FAIL abort_early_ren: got %0d pulses want 0", rc); end
    tick(3000, 1);
    n_tests++; if (ren !== 1'b1) begin n_fail++; $display("FAIL abort_new_window: got %b want 1", ren); end
  endtask

  task automatic test_random();
    int d;
    do_reset();
    foreach (tbl[i]) tbl[i] = 16'($urandom);
    for (int i = 0; i < 900; i++) begin
      case ($urandom_range(0, 9))
        0: d = -32768;
        1: d = 32767;
        default: d = $signed(16'($urandom));
      endcase
      tick(d, $urandom_range(0, 2) != 0);
      n_tests++; if (dout_valid !== e2v) begin n_fail++; $display("FAIL rand_valid @%0d: got %b want %b", i, dout_valid, e2v); end
      n_tests++; if (int'(dout) != e2) begin n_fail++; $display("FAIL rand_dout @%0d: got %0d want %0d", i, dout, e2); end
      n_tests++; if (ren !== (cyc == m_ren_at)) begin n_fail++; $display("FAIL rand_ren @%0d: got %b want %b", i, ren, cyc == m_ren_at); end
      n_tests++; if (gain_upd !== m_upd) begin n_fail++; $display("FAIL rand_upd @%0d: got %b want %b", i, gain_upd, m_upd); end
      n_tests++; if (cur_gain !== 16'(m_gain)) begin n_fail++; $display("FAIL rand_gain @%0d: got %h want %h", i, cur_gain, 16'(m_gain)); end
      if (ren) begin
        n_tests++; if (radd !== 8'(m_radd)) begin n_fail++; $display("FAIL rand_radd @%0d: got %0d want %0d", i, radd, m_radd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_window();
    test_saturate();
    test_gaps();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
